bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Iterative (shift-and-add-3) binary-to-BCD converter. It sits directly upstream of the 7-segment decoder stage in the count-binary game.
- It takes the binary score/target value and produces one 4-bit BCD digit per display position. Each digit feeds a decoder instance.
- It uses one shift per clock with a start/busy/done handshake, which keeps area small for the tile.

Parameters:
- IN_WIDTH, 8, width of the binary input.
- DIGITS, 3, number of BCD output digits (digit 0 = least significant).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request conversion of bin_in; accepted only when busy=0.
- bin_in  input  IN_WIDTH  binary value, sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; bcd_out/overflow are valid and updated in this cycle.
- bcd_out  output  4*DIGITS  packed BCD result, digit i at [4i+3:4i]; held until the next done.
- overflow  output  1  value exceeded 10^DIGITS-1; updated with done, held.
- blank_mask  output  DIGITS  bit i=1 means digit i is a leading zero (see Optional Feature).

Behaviour:
- Reset is synchronous and active-high: one clock, with the reset (rst) held high at the rising edge.
- Reset values: busy=0, done=0, bcd_out=0, overflow=0, blank_mask=0, FSM=IDLE, shift count=0.
- FSM states:
  - IDLE: busy=0. On start=1, load shift register with bin_in, clear the BCD scratch (4*DIGITS bits), clear the sticky carry, set count=IN_WIDTH, go to CONV.
  - CONV: busy=1. Each cycle, every scratch digit >=5 gets +3 (4-bit, no cross-digit carry). Then {carry, scratch, shift} shifts left by 1. The bit shifted out of the top scratch digit ORs into the sticky carry. count decrements. When count reaches 1 this cycle, go to IDLE and register results.
- Result registration, on the transition out of CONV:
  - done=1 for exactly one cycle.
  - overflow=sticky carry.
  - bcd_out=scratch, or all digits 4'd9 if overflow.
- Latency: start sampled at edge k; busy=1 for cycles k+1..k+IN_WIDTH; done=1 and new bcd_out visible in cycle k+IN_WIDTH+1, where busy=0.
- Start handling:
  - start while busy=1 is ignored; no queueing, no error.
  - start in the done cycle is accepted, so back-to-back conversions run every IN_WIDTH+1 cycles.
- bin_in changes during CONV have no effect.
- Reset mid-CONV aborts the conversion: no done, bcd_out returns to 0.
- IN_WIDTH such that 2^IN_WIDTH-1 <= 10^DIGITS-1: overflow is structurally never 1.

Optional Feature:
- Macro: BIN2BCD_LZ_BLANK_EN.
- Defined:
  - blank_mask is registered with done.
  - Bit i=1 if digit i and all higher digits are 0, for i>=1.
  - Bit 0 is always 0, so the value 0 shows a single "0".
  - On overflow, blank_mask=0.
  - The top level uses the mask to force segments off.
- Not defined: blank_mask is constant 0 and no mask logic is synthesised.

Decomposition:
- Shared include header, guarded like the existing decoder file, holds:
  - BCD digit width constant (4).
  - Add-3 threshold constant (5).
  - FSM state encodings (IDLE=1'b0, CONV=1'b1).
- Sub-module bin2bcd_digit_adj: combinational 4-bit "if >=5 then +3" cell, instantiated DIGITS times via generate.

Test Plan (IN_WIDTH=8, DIGITS=3 unless stated):
- Reset, then bin_in=8'd0 with start -> done after 9 cycles; bcd_out=12'h000, overflow=0; with macro, blank_mask=3'b110.
- bin_in=8'd255 -> bcd_out=12'h255, overflow=0, blank_mask=3'b000; busy high exactly 8 cycles.
- bin_in=8'd99, then start again in the done cycle with bin_in=8'd7 -> first done bcd_out=12'h099 (mask 3'b100), second done 9 cycles later bcd_out=12'h007 (mask 3'b110).
- DIGITS=2, bin_in=8'd200 -> overflow=1, bcd_out=8'h99, blank_mask=2'b00.
- bin_in=8'd42 converting; pulse start with bin_in=8'd13 at cycle k+3 -> ignored; result 12'h042 at k+9.
- Start 8'd123, assert rst at cycle k+4 for one cycle -> no done pulse, bcd_out=0, busy=0 next cycle; a new start then converts normally.

Source files
------------

// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants and FSM state type for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

    // Width of one BCD digit.
    localparam int unsigned BcdW = 4;

    // A digit at or above this value gets +3 before the next shift.
    localparam logic [BcdW-1:0] AddThresh = 4'd5;
    localparam logic [BcdW-1:0] AddVal    = 4'd3;

    // Digit value forced into every position when the result saturates.
    localparam logic [BcdW-1:0] BcdNine   = 4'd9;

    typedef enum logic {
        StIdle = 1'b0,
        StConv = 1'b1
    } state_e;

endpackage

// File: rtl/bin2bcd_digit_adj.sv
// Combinational shift-and-add-3 correction for a single BCD digit.
module bin2bcd_digit_adj
    import bin2bcd_seq_pkg::*;
(
    input  logic [BcdW-1:0] digit_i,
    output logic [BcdW-1:0] digit_o
);

    // Digits >= 5 would become >= 10 after the shift, so pre-correct them by +3.
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= AddThresh) begin
            digit_o = digit_i + AddVal;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter, one shift per clock, start/busy/done handshake.
// Optional leading-zero mask: define BIN2BCD_LZ_BLANK_EN.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned DIGITS   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [IN_WIDTH-1:0]    bin_in,
    output logic                   busy,
    output logic                   done,
    output logic [BcdW*DIGITS-1:0] bcd_out,
    output logic                   overflow,
    output logic [DIGITS-1:0]      blank_mask
);

    localparam int unsigned SW   = BcdW * DIGITS;
    localparam int unsigned CntW = $clog2(IN_WIDTH + 1);

    state_e              state_q, state_d;
    logic [IN_WIDTH-1:0] shift_q, shift_d;
    logic [SW-1:0]       scratch_q, scratch_d;
    logic                carry_q, carry_d;
    logic [CntW-1:0]     count_q, count_d;
    logic                done_q, done_d;
    logic [SW-1:0]       bcd_q, bcd_d;
    logic                ovf_q, ovf_d;

    logic [SW-1:0]          adj;
    logic [SW+IN_WIDTH:0]   shifted;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bin2bcd_digit_adj u_adj (
            .digit_i (scratch_q[g*BcdW +: BcdW]),
            .digit_o (adj[g*BcdW +: BcdW])
        );
    end

    // Top bit is the digit-overflow bit that feeds the sticky carry.
    assign shifted = {adj, shift_q, 1'b0};

    // Next-state: load on accepted start, shift while converting, register results on exit.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        carry_d   = carry_q;
        count_d   = count_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shift_d   = bin_in;
                    scratch_d = '0;
                    carry_d   = 1'b0;
                    count_d   = CntW'(IN_WIDTH);
                    state_d   = StConv;
                end
            end
            StConv: begin
                shift_d   = shifted[IN_WIDTH-1:0];
                scratch_d = shifted[SW+IN_WIDTH-1 -: SW];
                carry_d   = carry_q | shifted[SW+IN_WIDTH];
                count_d   = count_q - CntW'(1);
                if (count_q == CntW'(1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    ovf_d   = carry_d;
                    bcd_d   = carry_d ? {DIGITS{BcdNine}} : scratch_d;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            scratch_q <= '0;
            carry_q   <= 1'b0;
            count_q   <= '0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            carry_q   <= carry_d;
            count_q   <= count_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef BIN2BCD_LZ_BLANK_EN
    logic [DIGITS-1:0] mask_q, mask_d, mask_new;
    logic              zero_run;

    // Bit i set when digit i and every higher digit are zero; digit 0 always shown.
    always_comb begin
        zero_run = 1'b1;
        mask_new = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            zero_run = zero_run & (scratch_d[(DIGITS-1-i)*BcdW +: BcdW] == '0);
            mask_new[DIGITS-1-i] = zero_run;
        end
        mask_new[0] = 1'b0;
        mask_d = mask_q;
        if (done_d) begin
            mask_d = ovf_d ? '0 : mask_new;
        end
    end

    // Mask register, updated together with bcd_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign blank_mask = mask_q;
`else
    assign blank_mask = '0;
`endif

    assign busy     = (state_q == StConv);
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: 3-digit instance plus a 2-digit instance for overflow.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [7:0]  bin_a, bin_b;
    logic        busy_a, done_a, ovf_a;
    logic        busy_b, done_b, ovf_b;
    logic [11:0] bcd_a;
    logic [7:0]  bcd_b;
    logic [2:0]  mask_a;
    logic [1:0]  mask_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.IN_WIDTH(8), .DIGITS(3)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .start      (start_a),
        .bin_in     (bin_a),
        .busy       (busy_a),
        .done       (done_a),
        .bcd_out    (bcd_a),
        .overflow   (ovf_a),
        .blank_mask (mask_a)
    );

    bin2bcd_seq #(.IN_WIDTH(8), .DIGITS(2)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .start      (start_b),
        .bin_in     (bin_b),
        .busy       (busy_b),
        .done       (done_b),
        .bcd_out    (bcd_b),
        .overflow   (ovf_b),
        .blank_mask (mask_b)
    );

    // Reference model: decimal digits by division, saturated to all nines on overflow.
    function automatic logic [11:0] ref_bcd(int v, int nd);
        logic [11:0] r = '0;
        int p = 1;
        bit ovf = (v > 10**nd - 1);
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = ovf ? 4'd9 : 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(int v, int nd);
        return v > 10**nd - 1;
    endfunction

    // Digit i (i>=1) is a leading zero exactly when the value is below 10^i.
    function automatic logic [2:0] ref_mask(int v, int nd);
        logic [2:0] m = '0;
`ifdef BIN2BCD_LZ_BLANK_EN
        if (!ref_ovf(v, nd)) begin
            for (int i = 1; i < nd; i++) begin
                m[i] = (v < 10**i);
            end
        end
`endif
        return m;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles (and busy cycles) from just after the accepting edge to the done cycle.
    task automatic wait_done_a(output int n, output int nbusy);
        n = 0;
        nbusy = 0;
        while (done_a !== 1'b1 && n < 40) begin
            if (busy_a === 1'b1) nbusy++;
            bin_a = 8'($urandom);
            step();
            n++;
        end
    endtask

    task automatic check_result_a(string tag, int v);
        chk({tag, "_bcd"}, 64'(bcd_a), 64'(ref_bcd(v, 3)));
        chk({tag, "_ovf"}, 64'(ovf_a), 64'(ref_ovf(v, 3)));
        chk({tag, "_mask"}, 64'(mask_a), 64'(ref_mask(v, 3)));
        chk({tag, "_busy_in_done"}, 64'(busy_a), 64'd0);
    endtask

    // Accept a conversion on DUT A, wait for done, check latency and result.
    task automatic convert_a(string tag, int v);
        int n, nb;
        start_a = 1'b1;
        bin_a = 8'(v);
        step();
        start_a = 1'b0;
        wait_done_a(n, nb);
        chk({tag, "_lat"}, 64'(n), 64'd8);
        check_result_a(tag, v);
    endtask

    task automatic convert_b(string tag, int v);
        int n = 0;
        start_b = 1'b1;
        bin_b = 8'(v);
        step();
        start_b = 1'b0;
        while (done_b !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'd8);
        chk({tag, "_bcd"}, 64'(bcd_b), 64'(ref_bcd(v, 2)));
        chk({tag, "_ovf"}, 64'(ovf_b), 64'(ref_ovf(v, 2)));
        chk({tag, "_mask"}, 64'(mask_b), 64'(ref_mask(v, 2)));
    endtask

    initial begin
        int n, nb, v;
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        bin_a = '0;
        bin_b = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_bcd", 64'(bcd_a), 64'd0);
        chk("rst_ovf", 64'(ovf_a), 64'd0);
        chk("rst_mask", 64'(mask_a), 64'd0);

        // Zero input
        convert_a("zero", 0);
        step();
        chk("done_one_cycle", 64'(done_a), 64'd0);
        chk("hold_bcd", 64'(bcd_a), 64'(ref_bcd(0, 3)));

        // Max input, busy exactly 8 cycles
        start_a = 1'b1;
        bin_a = 8'd255;
        step();
        start_a = 1'b0;
        wait_done_a(n, nb);
        chk("max_busy_cycles", 64'(nb), 64'd8);
        check_result_a("max", 255);

        // Back-to-back: start in the done cycle
        convert_a("b2b_first", 99);
        start_a = 1'b1;
        bin_a = 8'd7;
        step();
        start_a = 1'b0;
        wait_done_a(n, nb);
        chk("b2b_second_lat", 64'(n), 64'd8);
        check_result_a("b2b_second", 7);

        // Start while busy is ignored
        start_a = 1'b1;
        bin_a = 8'd42;
        step();
        start_a = 1'b0;
        step();
        step();
        start_a = 1'b1;
        bin_a = 8'd13;
        step();
        start_a = 1'b0;
        wait_done_a(n, nb);
        chk("ignore_lat", 64'(n), 64'd5);
        check_result_a("ignore", 42);
        step();
        chk("ignore_no_second_done", 64'(busy_a), 64'd0);

        // Reset mid-conversion aborts
        start_a = 1'b1;
        bin_a = 8'd123;
        step();
        start_a = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", 64'(busy_a), 64'd0);
        chk("abort_bcd", 64'(bcd_a), 64'd0);
        chk("abort_done", 64'(done_a), 64'd0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (done_a === 1'b1) n++;
            step();
        end
        chk("abort_no_done", 64'(n), 64'd0);
        convert_a("after_abort", 123);

        // Randomized values against the model
        for (int i = 0; i < 24; i++) begin
            v = int'($urandom_range(0, 255));
            convert_a("rand", v);
        end

        // Two-digit instance: overflow boundary
        convert_b("d2_200", 200);
        convert_b("d2_99", 99);
        convert_b("d2_100", 100);
        convert_b("d2_5", 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
